// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the instruction-fetch / data-access arbiter in front
// of a byte-wide RAM: FSM state encoding, request ownership, mem_rw and
// mem_size codes, bus widths and the size-to-byte-count helper.
package mem_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;
  localparam int RW_W   = 2;
  localparam int SIZE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam logic [RW_W-1:0] RW_LOAD  = 2'b01;
  localparam logic [RW_W-1:0] RW_STORE = 2'b10;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'b10;

  localparam logic [CNT_W-1:0] NB_BYTE = 3'd1;
  localparam logic [CNT_W-1:0] NB_HALF = 3'd2;
  localparam logic [CNT_W-1:0] NB_WORD = 3'd4;

  // Size code 11 is treated as a word transfer.
  function automatic logic [CNT_W-1:0] size_to_bytes(input logic [SIZE_W-1:0] size);
    case (size)
      SIZE_BYTE: return NB_BYTE;
      SIZE_HALF: return NB_HALF;
      SIZE_WORD: return NB_WORD;
      default:   return NB_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port (always 4-byte reads) and a data port
// (1/2/4-byte loads and stores) onto a byte-wide RAM with one cycle of read
// latency. Data port wins ties; a running transfer is never preempted.
// Transfers are little-endian, byte k at latched_addr + k (wrapping).
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   if_req/if_addr/if_flush    fetch request, address, abort
//   if_done/if_inst            fetch-complete pulse, fetched word
//   mem_req/mem_rw/mem_addr/
//   mem_size/mem_wdata         data access request (rw 01 load, 10 store)
//   mem_done/mem_rdata         access-complete pulse, zero-extended load data
//   ram_rw/ram_addr/ram_wdata  byte RAM command (rw 1 = write)
//   ram_rdata                  byte RAM read data, valid one cycle after addr
//
// Build option: ARB_FLUSH_EN makes if_flush abort a fetch in IF_RD and
// suppress if_req in IDLE. Without it if_flush is ignored.
//
// state     | meaning
// IDLE      | sample requests, latch winner
// IF_RD     | fetch read, byte k addressed at cnt=k, captured at cnt=k+1
// MEM_RD    | data load, same timing as IF_RD
// MEM_WR    | data store, one byte written per cycle
// DONE      | one-cycle completion pulse to owner, RAM idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              if_flush,
  input  logic              mem_req,
  input  logic [RW_W-1:0]   mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [SIZE_W-1:0] mem_size,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  input  logic [BYTE_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  nbytes_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] if_inst_q;
  logic [DATA_W-1:0] mem_rdata_q;

  logic              flush_act;
  logic              mem_valid;
  logic              if_valid;
  logic              rd_active;
  logic              capture;
  logic              last_rd;
  logic [1:0]        rd_idx;
  logic [DATA_W-1:0] rd_merged;

`ifdef ARB_FLUSH_EN
  assign flush_act = if_flush;
`else
  logic unused_if_flush;
  assign unused_if_flush = if_flush;
  assign flush_act       = 1'b0;
`endif

  assign mem_valid = mem_req && ((mem_rw == RW_LOAD) || (mem_rw == RW_STORE));
  assign if_valid  = if_req && !flush_act;

  // A flushed fetch must not capture, so the final if_inst write is gated too.
  assign rd_active = ((state_q == ST_IF_RD) && !flush_act) || (state_q == ST_MEM_RD);
  assign capture   = rd_active && (cnt_q != '0);
  assign last_rd   = rd_active && (cnt_q == nbytes_q);

  // Data arriving at cnt=k belongs to byte k-1; the last byte is merged
  // combinationally so it lands in the owner's register on the same edge.
  assign rd_idx = cnt_q[1:0] - 2'(1);
  always_comb begin
    rd_merged = buf_q;
    rd_merged[{rd_idx, 3'b000} +: BYTE_W] = ram_rdata;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (mem_valid) begin
          state_d = (mem_rw == RW_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        end else if (if_valid) begin
          state_d = ST_IF_RD;
        end
      end
      ST_IF_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (flush_act) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == nbytes_q) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_MEM_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == nbytes_q) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_MEM_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == (nbytes_q - CNT_W'(1))) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if_done   = 1'b0;
    mem_done  = 1'b0;
    case (state_q)
      ST_IF_RD, ST_MEM_RD: begin
        if (cnt_q < nbytes_q) ram_addr = addr_q + ADDR_W'(cnt_q);
      end
      ST_MEM_WR: begin
        ram_rw    = 1'b1;
        ram_addr  = addr_q + ADDR_W'(cnt_q);
        ram_wdata = wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
      end
      ST_DONE: begin
        if_done  = (owner_q == OWN_IF);
        mem_done = (owner_q == OWN_MEM);
      end
      default: ;
    endcase
  end

  // Request latch and byte assembler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_IF;
      addr_q      <= '0;
      nbytes_q    <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        buf_q <= '0;
        if (mem_valid) begin
          owner_q  <= OWN_MEM;
          addr_q   <= mem_addr;
          nbytes_q <= size_to_bytes(mem_size);
          wdata_q  <= mem_wdata;
        end else if (if_valid) begin
          owner_q  <= OWN_IF;
          addr_q   <= if_addr;
          nbytes_q <= NB_WORD;
        end
      end
      if (capture) buf_q <= rd_merged;
      if (last_rd) begin
        if (owner_q == OWN_IF) if_inst_q <= rd_merged;
        else                   mem_rdata_q <= rd_merged;
      end
    end
  end

  assign if_inst   = if_inst_q;
  assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst;
  logic        mem_req, mem_done;
  logic [1:0]  mem_rw, mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ram_rw;
  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .if_flush(if_flush),
    .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // RAM seen by the DUT, and the bench's own expected image of it.
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction
  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int k = 0; k < n; k++) r = r | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return r;
  endfunction
  function automatic int nbytes_of(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  initial begin
    ram_rdata = 8'h00;
    forever begin
      @(posedge clk);
      ram_rdata <= ram_rd(ram_addr);
    end
  end
  initial forever begin
    @(negedge clk);
    if (ram_rw) ram[ram_addr] = ram_wdata;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic wait_done(input bit is_mem, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (is_mem ? mem_done : if_done) begin
        lat = k;
        return;
      end
    end
  endtask

  // kind: 0 fetch, 1 load, 2 store, 3 fetch with an invalid data request alongside
  task automatic run_txn(input string nm, input int kind, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_data);
    int n, exp_lat, lat, beat, exp_beats;
    bit wr_ok, other_done, is_mem;
    logic [31:0] if_prev, mem_prev;
    is_mem    = (kind == 1) || (kind == 2);
    n         = is_mem ? nbytes_of(size) : 4;
    exp_lat   = (kind == 2) ? n + 1 : n + 2;
    exp_beats = (kind == 2) ? n : 0;
    if_prev   = if_inst;
    mem_prev  = mem_rdata;
    @(negedge clk);
    if (!is_mem) begin
      if_req  = 1'b1;
      if_addr = addr;
    end
    if (is_mem) begin
      mem_req   = 1'b1;
      mem_rw    = (kind == 1) ? 2'b01 : 2'b10;
      mem_addr  = addr;
      mem_size  = size;
      mem_wdata = wdata;
    end
    if (kind == 3) begin
      mem_req  = 1'b1;
      mem_rw   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      mem_addr = $urandom;
    end
    lat = -1; beat = 0; wr_ok = 1'b1; other_done = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_rw) begin
        if (ram_addr !== addr + 32'(beat) || ram_wdata !== 8'((wdata >> (8 * beat)) & 32'hFF))
          wr_ok = 1'b0;
        beat++;
      end
      if (is_mem ? mem_done : if_done) begin
        lat = k;
        break;
      end
      if (is_mem ? if_done : mem_done) other_done = 1'b1;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " ram idle in done"}, {ram_rw, ram_addr, ram_wdata}, 64'h0);
    chk({nm, " write beats"}, {wr_ok, 32'(beat)}, {1'b1, 32'(exp_beats)});
    if (kind == 1) chk({nm, " data"}, mem_rdata, exp_data);
    if (kind == 0 || kind == 3) chk({nm, " data"}, if_inst, exp_data);
    if (is_mem) chk({nm, " other side held"}, {other_done, if_inst}, {1'b0, if_prev});
    else        chk({nm, " other side held"}, {other_done, mem_rdata}, {1'b0, mem_prev});
    @(posedge clk);
    #1;
    if_req = 1'b0; mem_req = 1'b0; mem_rw = 2'b00;
    @(negedge clk);
    chk({nm, " done is a pulse"}, {if_done, mem_done}, 64'h0);
    if (kind == 2)
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = 8'((wdata >> (8 * k)) & 32'hFF);
  endtask

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[11];

  initial begin
    int lat, bad, kind, n;
    logic [31:0] a, w, prev;
    logic [1:0]  sz;

    vt[0]  = '{"fetch 0x100",       0, 32'h0000_0100, 2'b10, 32'h0,         32'h4433_2211};
    vt[1]  = '{"store half 0x301",  2, 32'h0000_0301, 2'b01, 32'h0000_BEEF, 32'h0};
    vt[2]  = '{"load byte 0x302",   1, 32'h0000_0302, 2'b00, 32'h0,         32'h0000_00BE};
    vt[3]  = '{"load byte 0x301",   1, 32'h0000_0301, 2'b00, 32'h0,         32'h0000_00EF};
    vt[4]  = '{"load word wrap",    1, 32'hFFFF_FFFE, 2'b10, 32'h0,         32'hB1B0_A2A1};
    vt[5]  = '{"load half 0x100",   1, 32'h0000_0100, 2'b01, 32'h0,         32'h0000_2211};
    vt[6]  = '{"store word 0x400",  2, 32'h0000_0400, 2'b10, 32'h1234_5678, 32'h0};
    vt[7]  = '{"load size11 0x400", 1, 32'h0000_0400, 2'b11, 32'h0,         32'h1234_5678};
    vt[8]  = '{"store byte 0x401",  2, 32'h0000_0401, 2'b00, 32'hFFFF_FFAB, 32'h0};
    vt[9]  = '{"load word 0x400",   1, 32'h0000_0400, 2'b10, 32'h0,         32'h1234_AB78};
    vt[10] = '{"fetch bad mem_rw",  3, 32'h0000_0200, 2'b10, 32'h0,         32'hEFBE_ADDE};

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'h200, 8'hDE); preload(32'h201, 8'hAD);
    preload(32'h202, 8'hBE); preload(32'h203, 8'hEF);
    preload(32'hFFFF_FFFE, 8'hA1); preload(32'hFFFF_FFFF, 8'hA2);
    preload(32'h0, 8'hB0); preload(32'h1, 8'hB1);

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_rw = 2'b00; mem_addr = '0; mem_size = 2'b00; mem_wdata = '0;
    #2;
    chk("reset done pulses", {if_done, mem_done}, 64'h0);
    chk("reset read data", {if_inst, mem_rdata}, 64'h0);
    chk("reset ram bus", {ram_rw, ram_addr, ram_wdata}, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_txn(vt[i].nm, vt[i].kind, vt[i].addr, vt[i].size, vt[i].wdata, vt[i].exp);
    chk("ram 0x301/0x302 after half store", {ram_rd(32'h301), ram_rd(32'h302)}, {8'hEF, 8'hBE});

    // Invalid mem_rw codes alone start nothing.
    bad = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_addr = 32'h100; mem_size = 2'b10;
    for (int k = 0; k < 4; k++) begin
      mem_rw = (k % 2 == 0) ? 2'b00 : 2'b11;
      @(negedge clk);
      if (ram_addr !== 32'h0 || mem_done || if_done) bad++;
    end
    mem_req = 1'b0; mem_rw = 2'b00;
    chk("invalid mem_rw ignored", 64'(bad), 64'h0);

    // Simultaneous requests: data side first, then the held fetch.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_rw = 2'b01; mem_addr = 32'h200; mem_size = 2'b10;
    wait_done(1'b1, 20, lat);
    chk("tie mem latency", 64'(lat), 64'd6);
    chk("tie mem data / no fetch done", {if_done, mem_rdata}, {1'b0, 32'hEFBE_ADDE});
    @(posedge clk); #1;
    mem_req = 1'b0; mem_rw = 2'b00;
    wait_done(1'b0, 20, lat);
    chk("tie fetch latency", 64'(lat), 64'd7);
    chk("tie fetch data", if_inst, 32'h4433_2211);
    @(posedge clk); #1;
    if_req = 1'b0;

    // A data request arriving mid-fetch waits.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    repeat (2) @(negedge clk);
    mem_req = 1'b1; mem_rw = 2'b01; mem_addr = 32'h302; mem_size = 2'b00;
    wait_done(1'b0, 20, lat);
    chk("no preempt fetch latency", {mem_done, 32'(lat)}, {1'b0, 32'd4});
    @(posedge clk); #1;
    if_req = 1'b0;
    wait_done(1'b1, 20, lat);
    chk("queued load latency", 64'(lat), 64'd4);
    chk("queued load data", mem_rdata, 32'h0000_00BE);
    @(posedge clk); #1;
    mem_req = 1'b0; mem_rw = 2'b00;

    // Reset while the third fetch byte is addressed.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk);
    chk("pre-reset third byte addr", ram_addr, 32'h102);
    rst_n = 1'b0;
    #1;
    chk("reset mid-fetch outputs", {if_inst, mem_rdata}, 64'h0);
    chk("reset mid-fetch ram bus", {if_done, ram_rw, ram_addr, ram_wdata}, 64'h0);
    if_req = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (if_done || mem_done) bad++;
    end
    chk("no done after reset", 64'(bad), 64'h0);
    rst_n = 1'b1;
    run_txn("fetch after reset", 0, 32'h100, 2'b10, 32'h0, 32'h4433_2211);

    // Fetch abort at cnt=2.
    @(negedge clk);
    prev = if_inst;
    if_req = 1'b1; if_addr = 32'h200;
    repeat (3) @(negedge clk);
    if_flush = 1'b1;
`ifdef ARB_FLUSH_EN
    @(posedge clk); #1;
    if_flush = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("flush returns to idle", {ram_rw, ram_addr}, 64'h0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (if_done) bad++;
    end
    chk("flush no done, inst held", {32'(bad), if_inst}, {32'h0, prev});
    @(negedge clk);
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
    chk("flush suppresses idle fetch", {if_done, ram_addr}, 64'h0);
    repeat (6) @(negedge clk);
`else
    wait_done(1'b0, 20, lat);
    chk("flush ignored latency", 64'(lat), 64'd3);
    chk("flush ignored data", if_inst, 32'hEFBE_ADDE);
    @(posedge clk); #1;
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk);
`endif

    // Random traffic against the bench's memory image.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      sz   = 2'($urandom_range(0, 3));
      w    = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h500 + 32'($urandom_range(0, 31));
      n = (kind == 1 || kind == 2) ? nbytes_of(sz) : 4;
      run_txn($sformatf("rand%0d k%0d", i, kind), kind, a, sz, w, ref_word(a, n));
    end

    bad = 0;
    foreach (ram[k]) if (ram[k] !== ref_rd(k)) bad++;
    foreach (ref_mem[k]) if (ram_rd(k) !== ref_mem[k]) bad++;
    chk("final ram image", 64'(bad), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, maximum transfer width; transfers are 1/2/4 bytes.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports if_req in 1, if_addr in ADDR_W: instruction-fetch request, always a 4-byte read.
REQ-006 SHALL have ports if_done out 1, if_inst out DATA_W: fetch-complete pulse and the fetched word.
REQ-007 SHALL have port if_flush  in  1  fetch abort; functional only when ARB_FLUSH_EN is defined.
REQ-008 SHALL have ports mem_req in 1, mem_rw in 2, mem_addr in ADDR_W, mem_size in 2, mem_wdata in DATA_W: data access; mem_rw 01=load, 10=store; mem_size 00=byte, 01=half, 10=word.
REQ-009 SHALL have ports mem_done out 1, mem_rdata out DATA_W: access-complete pulse; load data zero-extended.
REQ-010 SHALL have ports ram_rw out 1 (0=read, 1=write), ram_addr out ADDR_W, ram_wdata out 8, ram_rdata in 8: byte-wide RAM; read data valid the cycle after the address is presented.

Function
REQ-011 SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR, DONE, with a byte counter cnt of 3 bits.
REQ-012 In IDLE, mem_req with mem_rw 01 or 10 SHALL win over if_req; the winner is latched (addr, size, wdata, owner) and cnt is cleared.
REQ-013 SHALL treat mem_req with mem_rw 00 or 11 as no request.
REQ-014 SHALL not preempt a transfer in progress; a request arriving mid-transfer waits until IDLE.
REQ-015 Byte k SHALL use ram_addr = latched_addr + k, modulo 2^ADDR_W, so 0xFFFFFFFF+1 wraps to 0x00000000.
REQ-016 Byte order SHALL be little-endian: byte k maps to bits [8k+7:8k].
REQ-017 Reads SHALL present byte k at cnt=k and capture ram_rdata into byte k-1 at cnt=k (k>=1); the last byte is captured one cycle after its address.
REQ-018 An N-byte read SHALL pulse done in cycle N+2 after the IDLE cycle that sampled the request.
REQ-019 Writes SHALL drive ram_rw=1 with byte k of latched wdata for N cycles; done pulses in cycle N+1.
REQ-020 DONE SHALL last one cycle: owner's done=1, RAM idle, no request sampled; next state is IDLE.
REQ-021 Requesters SHALL hold req and inputs stable until done and drop req in the cycle after done.
REQ-022 if_inst and mem_rdata SHALL hold their last value until the next completion of the same owner.
REQ-023 In IDLE and DONE, ram_rw=0, ram_addr=0, ram_wdata=0.
REQ-024 mem_size 11 SHALL be treated as word.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, cnt=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0, ram_rw=0, ram_addr=0, ram_wdata=0.
REQ-026 Reset mid-transfer SHALL abandon it with no done pulse; a partially written RAM region is not restored.

Configuration
REQ-027 With ARB_FLUSH_EN defined, if_flush=1 during IF_RD SHALL return the FSM to IDLE on the next edge with no if_done pulse and if_inst unchanged. In IDLE, if_flush SHALL suppress if_req for that cycle. In MEM states, if_flush SHALL have no effect.
REQ-028 Without ARB_FLUSH_EN, if_flush SHALL be ignored, and the port SHALL remain present.

Structure
REQ-029 State encodings, mem_rw codes, mem_size codes and bus widths SHALL live in the shared defines file; no local literals.
REQ-030 SHALL be a single module with no sub-module; the byte assembler is inline.

Verification
REQ-031 Only if_req, addr 0x100, RAM[0x100..0x103]=11 22 33 44 -> if_done in cycle 6, if_inst=0x44332211.
REQ-032 if_req and mem_req (load word 0x200) in the same IDLE cycle -> mem_done first; the fetch then starts and if_inst is correct.
REQ-033 Store half 0xBEEF at 0x301 -> RAM[0x301]=EF, RAM[0x302]=BE, mem_done in cycle 3; a byte load of 0x302 then returns 0x000000BE.
REQ-034 Word load at 0xFFFFFFFE -> bytes read from FFFFFFFE, FFFFFFFF, 0, 1.
REQ-035 rst_n low during the third byte of a fetch -> outputs zero at once, no done; after release, a new fetch completes normally.
REQ-036 With ARB_FLUSH_EN, if_flush at cnt=2 of a fetch -> IDLE next cycle, no if_done; without it -> if_done in cycle 6.
